// File: rtl/csi_rx_packet_handler_if.sv
// rtl/csi_rx_packet_handler_if.sv - aligner link and payload bus between the CSI-2 word aligner, packet handler and payload sink
//
// Purpose: groups the word stream coming from the aligner, the sync-loop
// feedback going back to it, and the forwarded payload byte bus.
// Signals:
//   word_in[15:0]      aligned word (lane0 in [7:0], lane1 in [15:8])
//   valid_in           word_in qualifier
//   packet_done        one-cycle end-of-packet pulse back to the aligner
//   wait_for_sync      high while the handler is idle or draining
//   payload_data[15:0] forwarded payload word, lane order preserved
//   payload_be[1:0]    per-lane byte enable
//   payload_valid      payload_data/payload_be qualifier
// Modports:
//   master  aligner/sink side (drives the word stream)
//   slave   packet handler side (consumes the word stream)

interface csi_rx_packet_handler_if;
  logic [15:0] word_in;
  logic        valid_in;
  logic        packet_done;
  logic        wait_for_sync;
  logic [15:0] payload_data;
  logic [1:0]  payload_be;
  logic        payload_valid;

  modport master (
    output word_in, valid_in,
    input  packet_done, wait_for_sync, payload_data, payload_be, payload_valid
  );

  modport slave (
    input  word_in, valid_in,
    output packet_done, wait_for_sync, payload_data, payload_be, payload_valid
  );
endinterface

// File: rtl/csi_rx_packet_handler.sv
// rtl/csi_rx_packet_handler.sv - CSI-2 2-lane packet header parser, sync strobes and payload forwarder
//
// Purpose: parses the 4-byte CSI-2 packet header from the lane-aligned word
// stream, strobes frame/line sync events for short packets, forwards
// long-packet payload bytes of data type PAYLOAD_DT with per-lane byte
// enables, drops the CRC, and closes the sync loop with the aligner.
// Ports:
//   byte_clock            byte clock, all logic on the rising edge
//   reset                 asynchronous active-high reset
//   enable                0 forces IDLE and masks all strobes
//   link (slave)          word stream in, packet_done/wait_for_sync and payload bus out
//   frame_start/frame_end/line_start/line_end  one-cycle short-packet strobes
//   in_frame/in_line      frame/line levels, updated together with their strobes
//   hdr_vc/hdr_dt/hdr_wc  fields of the most recent header
//   trunc_err             one-cycle pulse when valid_in drops mid-packet
// All outputs are registered.

module csi_rx_packet_handler #(
  parameter logic [5:0] PAYLOAD_DT = 6'h2B
) (
  input  logic                         byte_clock,
  input  logic                         reset,
  input  logic                         enable,
  csi_rx_packet_handler_if.slave       link,
  output logic                         frame_start,
  output logic                         frame_end,
  output logic                         line_start,
  output logic                         line_end,
  output logic                         in_frame,
  output logic                         in_line,
  output logic [1:0]                   hdr_vc,
  output logic [5:0]                   hdr_dt,
  output logic [15:0]                  hdr_wc,
  output logic                         trunc_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR1    = 2'd1,
    PAYLOAD = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [7:0]  wc_lo;
  logic [16:0] bytes_left;
  logic [16:0] byte_idx;

  logic        is_short;
  logic [15:0] wc_full;
  logic [1:0]  lane_be;

  logic        packet_done_d;
  logic        trunc_err_d;
  logic        frame_start_d;
  logic        frame_end_d;
  logic        line_start_d;
  logic        line_end_d;
  logic        in_frame_d;
  logic        in_line_d;
  logic [1:0]  be_d;
  logic        wait_for_sync_d;

  // Data types below 0x10 are short packets: header only, no payload/CRC.
  assign is_short = (hdr_dt < 6'h10);
  assign wc_full  = {link.word_in[7:0], wc_lo};

  // Lane k carries payload while its running byte index is below WC; the
  // remaining bytes of the packet are CRC.
  assign lane_be[0] = (byte_idx < {1'b0, hdr_wc});
  assign lane_be[1] = ((byte_idx + 17'd1) < {1'b0, hdr_wc});

  // State register
  always_ff @(posedge byte_clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (link.valid_in) state_nx = HDR1;
        end
        HDR1: begin
          if (!link.valid_in)  state_nx = DRAIN;
          else if (is_short)   state_nx = DRAIN;
          else                 state_nx = PAYLOAD;
        end
        PAYLOAD: begin
          if (!link.valid_in)                 state_nx = DRAIN;
          else if (bytes_left <= 17'd2)       state_nx = DRAIN;
        end
        DRAIN: begin
          if (!link.valid_in) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output decode: next values of the registered outputs
  always_comb begin
    packet_done_d = 1'b0;
    trunc_err_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    line_start_d  = 1'b0;
    line_end_d    = 1'b0;
    be_d          = 2'b00;
    in_frame_d    = in_frame;
    in_line_d     = in_line;

    if (enable) begin
      unique case (state)
        HDR1: begin
          if (!link.valid_in) begin
            packet_done_d = 1'b1;
            trunc_err_d   = 1'b1;
          end else if (is_short) begin
            packet_done_d = 1'b1;
            unique case (hdr_dt)
              6'h00:   frame_start_d = 1'b1;
              6'h01:   frame_end_d   = 1'b1;
              6'h02:   line_start_d  = 1'b1;
              6'h03:   line_end_d    = 1'b1;
              default: ;
            endcase
          end
        end
        PAYLOAD: begin
          if (!link.valid_in) begin
            packet_done_d = 1'b1;
            trunc_err_d   = 1'b1;
          end else begin
            if (hdr_dt == PAYLOAD_DT) be_d = lane_be;
            if (bytes_left <= 17'd2) packet_done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // frame_start opens a new frame, so any line left open is closed.
    if (frame_start_d) begin
      in_frame_d = 1'b1;
      in_line_d  = 1'b0;
    end
    if (frame_end_d)  in_frame_d = 1'b0;
    if (line_start_d) in_line_d  = 1'b1;
    if (line_end_d)   in_line_d  = 1'b0;

    wait_for_sync_d = (state_nx == IDLE) || (state_nx == DRAIN);
  end

  // Output and datapath registers
  always_ff @(posedge byte_clock or posedge reset) begin
    if (reset) begin
      link.packet_done   <= 1'b0;
      link.wait_for_sync <= 1'b1;
      link.payload_data  <= 16'h0000;
      link.payload_be    <= 2'b00;
      link.payload_valid <= 1'b0;
      frame_start        <= 1'b0;
      frame_end          <= 1'b0;
      line_start         <= 1'b0;
      line_end           <= 1'b0;
      in_frame           <= 1'b0;
      in_line            <= 1'b0;
      hdr_vc             <= 2'd0;
      hdr_dt             <= 6'd0;
      hdr_wc             <= 16'd0;
      trunc_err          <= 1'b0;
      wc_lo              <= 8'd0;
      bytes_left         <= 17'd0;
      byte_idx           <= 17'd0;
    end else begin
      link.packet_done   <= packet_done_d;
      link.wait_for_sync <= wait_for_sync_d;
      link.payload_be    <= be_d;
      link.payload_valid <= |be_d;
      frame_start        <= frame_start_d;
      frame_end          <= frame_end_d;
      line_start         <= line_start_d;
      line_end           <= line_end_d;
      in_frame           <= in_frame_d;
      in_line            <= in_line_d;
      trunc_err          <= trunc_err_d;

      if (enable && link.valid_in) begin
        unique case (state)
          IDLE: begin
            hdr_vc <= link.word_in[7:6];
            hdr_dt <= link.word_in[5:0];
            wc_lo  <= link.word_in[15:8];
          end
          HDR1: begin
            // word_in[15:8] is the header ECC and is not checked here.
            hdr_wc <= wc_full;
            if (!is_short) begin
              bytes_left <= {1'b0, wc_full} + 17'd2;
              byte_idx   <= 17'd0;
            end
          end
          PAYLOAD: begin
            link.payload_data <= link.word_in;
            byte_idx          <= byte_idx + 17'd2;
            bytes_left        <= (bytes_left > 17'd2) ? (bytes_left - 17'd2) : 17'd0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csi_rx_packet_handler.sv
// tb/tb_csi_rx_packet_handler.sv - directed self-checking bench for csi_rx_packet_handler

module tb_csi_rx_packet_handler;
  logic byte_clock = 1'b0;
  logic reset;
  logic enable;
  logic frame_start, frame_end, line_start, line_end, in_frame, in_line;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic trunc_err;

  int checks = 0;
  int errors = 0;

  csi_rx_packet_handler_if link();

  csi_rx_packet_handler #(.PAYLOAD_DT(6'h2B)) dut (
    .byte_clock  (byte_clock),
    .reset       (reset),
    .enable      (enable),
    .link        (link),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .line_start  (line_start),
    .line_end    (line_end),
    .in_frame    (in_frame),
    .in_line     (in_line),
    .hdr_vc      (hdr_vc),
    .hdr_dt      (hdr_dt),
    .hdr_wc      (hdr_wc),
    .trunc_err   (trunc_err)
  );

  always #5 byte_clock = ~byte_clock;

  // Present one word, clock it in, and leave time for registered outputs to settle.
  task automatic step(input logic [15:0] w, input logic v);
    link.word_in  = w;
    link.valid_in = v;
    @(posedge byte_clock);
    #1;
  endtask

  task automatic test_reset;
    logic [5:0] got;
    got = {link.wait_for_sync, link.packet_done, frame_start, in_frame, link.payload_valid, trunc_err};
    checks++;
    if (got !== 6'b100000) begin
      $display("FAIL reset_outputs got=%b exp=100000", got);
      errors++;
    end
    checks++;
    if ({hdr_wc, hdr_dt, hdr_vc} !== 24'h0) begin
      $display("FAIL reset_hdr got=%h exp=000000", {hdr_wc, hdr_dt, hdr_vc});
      errors++;
    end
  endtask

  // Short packets: {fs,fe,ls,le,in_frame,in_line} after the second header word.
  task automatic test_short_strobes;
    logic [5:0] dts [7];
    logic [5:0] exp [7];
    logic [5:0] got;
    dts = '{6'h00, 6'h02, 6'h00, 6'h02, 6'h03, 6'h01, 6'h05};
    exp = '{6'b100010, 6'b001011, 6'b100010, 6'b001011, 6'b000110, 6'b010000, 6'b000000};
    for (int i = 0; i < 7; i++) begin
      step({8'h00, 2'b00, dts[i]}, 1'b1);
      checks++;
      if (link.wait_for_sync !== 1'b0 || link.packet_done !== 1'b0) begin
        $display("FAIL short_hdr0_%0d got wfs=%b pd=%b exp wfs=0 pd=0", i, link.wait_for_sync, link.packet_done);
        errors++;
      end
      step(16'hEE00, 1'b1);
      got = {frame_start, frame_end, line_start, line_end, in_frame, in_line};
      checks++;
      if (got !== exp[i]) begin
        $display("FAIL short_strobes_%0d got=%b exp=%b", i, got, exp[i]);
        errors++;
      end
      checks++;
      if (link.packet_done !== 1'b1 || link.wait_for_sync !== 1'b1 || hdr_dt !== dts[i]) begin
        $display("FAIL short_done_%0d got pd=%b wfs=%b dt=%h exp pd=1 wfs=1 dt=%h",
                 i, link.packet_done, link.wait_for_sync, hdr_dt, dts[i]);
        errors++;
      end
      step(16'h0000, 1'b0);
      checks++;
      if ({frame_start, frame_end, line_start, line_end, link.packet_done} !== 5'b0) begin
        $display("FAIL short_pulse_width_%0d got=%b exp=00000",
                 i, {frame_start, frame_end, line_start, line_end, link.packet_done});
        errors++;
      end
    end
  endtask

  task automatic test_long_payload;
    step(16'h042B, 1'b1);
    step(16'hEE00, 1'b1);
    checks++;
    if (link.payload_valid !== 1'b0 || link.packet_done !== 1'b0 || link.wait_for_sync !== 1'b0) begin
      $display("FAIL long_hdr got pv=%b pd=%b wfs=%b exp 0 0 0", link.payload_valid, link.packet_done, link.wait_for_sync);
      errors++;
    end
    step(16'hA1A0, 1'b1);
    checks++;
    if ({link.payload_valid, link.payload_be, link.payload_data, link.packet_done} !== {1'b1, 2'b11, 16'hA1A0, 1'b0}) begin
      $display("FAIL long_beat0 got pv=%b be=%b d=%h pd=%b exp 1 11 a1a0 0",
               link.payload_valid, link.payload_be, link.payload_data, link.packet_done);
      errors++;
    end
    step(16'hA3A2, 1'b1);
    checks++;
    if ({link.payload_valid, link.payload_be, link.payload_data, link.packet_done} !== {1'b1, 2'b11, 16'hA3A2, 1'b0}) begin
      $display("FAIL long_beat1 got pv=%b be=%b d=%h pd=%b exp 1 11 a3a2 0",
               link.payload_valid, link.payload_be, link.payload_data, link.packet_done);
      errors++;
    end
    step(16'hC1C0, 1'b1);
    checks++;
    if (link.payload_valid !== 1'b0 || link.packet_done !== 1'b1 || link.wait_for_sync !== 1'b1) begin
      $display("FAIL long_crc got pv=%b pd=%b wfs=%b exp 0 1 1", link.payload_valid, link.packet_done, link.wait_for_sync);
      errors++;
    end
    checks++;
    if (hdr_wc !== 16'd4 || hdr_dt !== 6'h2B || hdr_vc !== 2'd0) begin
      $display("FAIL long_hdr_fields got wc=%h dt=%h vc=%h exp 0004 2b 0", hdr_wc, hdr_dt, hdr_vc);
      errors++;
    end
    // Aligner may keep valid high in DRAIN; header-looking words must be ignored.
    step(16'h0000, 1'b1);
    step(16'h0000, 1'b1);
    checks++;
    if (frame_start !== 1'b0 || link.packet_done !== 1'b0 || link.wait_for_sync !== 1'b1) begin
      $display("FAIL drain_ignore got fs=%b pd=%b wfs=%b exp 0 0 1", frame_start, link.packet_done, link.wait_for_sync);
      errors++;
    end
    step(16'h0000, 1'b0);
  endtask

  task automatic test_odd_wc;
    step(16'h032B, 1'b1);
    step(16'hEE00, 1'b1);
    step(16'hA1A0, 1'b1);
    checks++;
    if ({link.payload_valid, link.payload_be, link.payload_data} !== {1'b1, 2'b11, 16'hA1A0}) begin
      $display("FAIL odd_beat0 got pv=%b be=%b d=%h exp 1 11 a1a0", link.payload_valid, link.payload_be, link.payload_data);
      errors++;
    end
    step(16'hC0A2, 1'b1);
    checks++;
    if ({link.payload_valid, link.payload_be, link.payload_data, link.packet_done} !== {1'b1, 2'b01, 16'hC0A2, 1'b0}) begin
      $display("FAIL odd_beat1 got pv=%b be=%b d=%h pd=%b exp 1 01 c0a2 0",
               link.payload_valid, link.payload_be, link.payload_data, link.packet_done);
      errors++;
    end
    step(16'h55C1, 1'b1);
    checks++;
    if (link.payload_valid !== 1'b0 || link.packet_done !== 1'b1) begin
      $display("FAIL odd_done got pv=%b pd=%b exp 0 1", link.payload_valid, link.packet_done);
      errors++;
    end
    step(16'h0000, 1'b0);
  endtask

  task automatic test_wc_zero;
    step(16'h002B, 1'b1);
    step(16'hEE00, 1'b1);
    step(16'hC1C0, 1'b1);
    checks++;
    if (link.payload_valid !== 1'b0 || link.packet_done !== 1'b1 || hdr_wc !== 16'd0) begin
      $display("FAIL wc_zero got pv=%b pd=%b wc=%h exp 0 1 0000", link.payload_valid, link.packet_done, hdr_wc);
      errors++;
    end
    step(16'h0000, 1'b0);
  endtask

  task automatic test_other_dt;
    int pv_seen;
    pv_seen = 0;
    step(16'h0412, 1'b1);
    step(16'hEE00, 1'b1);
    step(16'hA1A0, 1'b1);
    pv_seen += link.payload_valid;
    step(16'hA3A2, 1'b1);
    pv_seen += link.payload_valid;
    checks++;
    if (link.packet_done !== 1'b0) begin
      $display("FAIL other_dt_early_done got pd=%b exp 0", link.packet_done);
      errors++;
    end
    step(16'hC1C0, 1'b1);
    pv_seen += link.payload_valid;
    checks++;
    if (link.packet_done !== 1'b1 || pv_seen !== 0) begin
      $display("FAIL other_dt_done got pd=%b pv_beats=%0d exp pd=1 pv_beats=0", link.packet_done, pv_seen);
      errors++;
    end
    checks++;
    if (hdr_dt !== 6'h12 || hdr_wc !== 16'd4) begin
      $display("FAIL other_dt_hdr got dt=%h wc=%h exp 12 0004", hdr_dt, hdr_wc);
      errors++;
    end
    step(16'h0000, 1'b0);
  endtask

  task automatic test_truncation;
    step(16'h082B, 1'b1);
    step(16'hEE00, 1'b1);
    step(16'hA1A0, 1'b1);
    checks++;
    if (link.payload_valid !== 1'b1 || trunc_err !== 1'b0) begin
      $display("FAIL trunc_first_beat got pv=%b te=%b exp 1 0", link.payload_valid, trunc_err);
      errors++;
    end
    step(16'hA3A2, 1'b0);
    checks++;
    if ({trunc_err, link.packet_done, link.payload_valid, link.wait_for_sync} !== 4'b1101) begin
      $display("FAIL trunc_pulse got te,pd,pv,wfs=%b exp 1101",
               {trunc_err, link.packet_done, link.payload_valid, link.wait_for_sync});
      errors++;
    end
    step(16'h0000, 1'b0);
    checks++;
    if ({trunc_err, link.packet_done, link.wait_for_sync} !== 3'b001) begin
      $display("FAIL trunc_after got te,pd,wfs=%b exp 001", {trunc_err, link.packet_done, link.wait_for_sync});
      errors++;
    end
    // Back in IDLE: a fresh short header must parse.
    step(16'h0000, 1'b1);
    step(16'hEE00, 1'b1);
    checks++;
    if (frame_start !== 1'b1 || in_frame !== 1'b1) begin
      $display("FAIL trunc_recover got fs=%b inf=%b exp 1 1", frame_start, in_frame);
      errors++;
    end
    step(16'h0000, 1'b0);
  endtask

  task automatic test_enable;
    step(16'h0100, 1'b1);
    enable = 1'b0;
    step(16'hEE00, 1'b1);
    checks++;
    if (frame_end !== 1'b0 || link.packet_done !== 1'b0 || link.wait_for_sync !== 1'b1 || in_frame !== 1'b1) begin
      $display("FAIL enable_mask got fe=%b pd=%b wfs=%b inf=%b exp 0 0 1 1",
               frame_end, link.packet_done, link.wait_for_sync, in_frame);
      errors++;
    end
    enable = 1'b1;
    step(16'h0000, 1'b0);
  endtask

  task automatic test_reset_mid_packet;
    step(16'h082B, 1'b1);
    step(16'hEE00, 1'b1);
    step(16'hA1A0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({link.payload_valid, link.payload_be, link.wait_for_sync, link.packet_done, in_frame, trunc_err} !== 7'b0001000) begin
      $display("FAIL reset_async got pv,be,wfs,pd,inf,te=%b exp 0001000",
               {link.payload_valid, link.payload_be, link.wait_for_sync, link.packet_done, in_frame, trunc_err});
      errors++;
    end
    checks++;
    if ({hdr_wc, hdr_dt, link.payload_data} !== 38'h0) begin
      $display("FAIL reset_async_data got wc=%h dt=%h d=%h exp 0", hdr_wc, hdr_dt, link.payload_data);
      errors++;
    end
    link.valid_in = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge byte_clock);
    #1;
    step(16'h022B, 1'b1);
    step(16'hEE00, 1'b1);
    step(16'hB1B0, 1'b1);
    checks++;
    if ({link.payload_valid, link.payload_be, link.payload_data, link.packet_done} !== {1'b1, 2'b11, 16'hB1B0, 1'b0}) begin
      $display("FAIL post_reset_beat got pv=%b be=%b d=%h pd=%b exp 1 11 b1b0 0",
               link.payload_valid, link.payload_be, link.payload_data, link.packet_done);
      errors++;
    end
    step(16'hC1C0, 1'b1);
    checks++;
    if (link.packet_done !== 1'b1 || link.payload_valid !== 1'b0 || hdr_wc !== 16'd2) begin
      $display("FAIL post_reset_done got pd=%b pv=%b wc=%h exp 1 0 0002", link.packet_done, link.payload_valid, hdr_wc);
      errors++;
    end
    step(16'h0000, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    enable        = 1'b1;
    link.word_in  = 16'h0000;
    link.valid_in = 1'b0;
    #12;
    test_reset();
    reset = 1'b0;
    @(posedge byte_clock);
    #1;
    step(16'h0000, 1'b0);
    test_short_strobes();
    test_long_payload();
    test_odd_wc();
    test_wc_zero();
    test_other_dt();
    test_truncation();
    test_enable();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csi_rx_packet_handler.md
Name: csi_rx_packet_handler

Overview:
- Consumes the lane-aligned 16-bit word stream from the CSI-2 word aligner: lane0 in [7:0], lane1 in [15:8], 2 lanes.
- Parses the 4-byte packet header and strobes frame/line sync events for short packets.
- Forwards long-packet payload bytes with per-lane byte enables and discards the CRC.
- Drives `packet_done` and `wait_for_sync` back to the aligner, closing the sync/resync loop.

Parameters:
- PAYLOAD_DT, 6'h2B: data type whose long-packet payload is forwarded. Other long packets are consumed silently.

Ports:
- byte_clock  in  1  byte clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- enable  in  1  0 forces IDLE and masks all strobes
- word_in  in  16  aligned word from aligner word_out
- valid_in  in  1  aligner valid_out
- packet_done  out  1  one-cycle pulse at end of each packet, to aligner packet_done
- wait_for_sync  out  1  high while IDLE or DRAIN, to aligner wait_for_sync
- frame_start, frame_end, line_start, line_end  out  1 each  one-cycle short-packet strobes
- in_frame  out  1  set by frame_start, cleared by frame_end
- in_line  out  1  set by line_start, cleared by line_end
- hdr_vc  out  2  virtual channel of last header
- hdr_dt  out  6  data type of last header
- hdr_wc  out  16  word count of last header
- payload_data  out  16  payload bytes, lane order preserved
- payload_be  out  2  per-lane byte enable
- payload_valid  out  1  payload_data/payload_be qualifier
- trunc_err  out  1  one-cycle pulse: valid_in fell mid-packet

Behaviour:
- Asynchronous reset values:
  - state=IDLE, wait_for_sync=1.
  - All other outputs and internal counters 0.
- All outputs are registered.
- States: IDLE, HDR1, PAYLOAD, DRAIN. enable=0 forces state IDLE on the next edge.
- IDLE:
  - On valid_in=1, capture DI=word_in[7:0] and WC[7:0]=word_in[15:8], then go to HDR1.
  - hdr_vc=DI[7:6], hdr_dt=DI[5:0].
- HDR1:
  - On valid_in=1, capture WC[15:8]=word_in[7:0]; the ECC byte word_in[15:8] is ignored. Update hdr_wc.
  - Short packet (DT<6'h10), next cycle: pulse frame_start for DT 0x00, frame_end for 0x01, line_start for 0x02, line_end for 0x03. Other short DTs produce no strobe.
  - Short packet, same next cycle: pulse packet_done and go to DRAIN.
  - Long packet (DT≥6'h10): load 17-bit bytes_left=WC+2 and byte_idx=0, then go to PAYLOAD.
- PAYLOAD, for each word with valid_in=1:
  - Lane k byte is payload iff byte_idx+k<WC.
  - payload_be[k] is set for each payload lane.
  - payload_valid=|payload_be, only when hdr_dt==PAYLOAD_DT.
  - payload_data is the registered word_in. Latency is 1 cycle.
  - Update byte_idx+=2 and bytes_left-=2, saturating at 0.
  - When bytes_left≤2 before the decrement, the packet is complete: pulse packet_done on the next cycle and go to DRAIN.
  - WC=0 gives a single CRC-only word with no payload_valid.
  - Odd WC: the last payload word has payload_be=2'b01. The CRC straddles into the next word.
  - Total words consumed after the header = ceil((WC+2)/2).
- Truncation: valid_in=0 while in HDR1 or PAYLOAD:
  - Pulse trunc_err and pulse packet_done.
  - No payload_valid for that cycle; go to DRAIN.
  - Sync strobes are not emitted.
- DRAIN:
  - Ignore word_in; the aligner keeps valid high for up to 2 cycles after packet_done.
  - On valid_in=0, go to IDLE.
- wait_for_sync is registered decode of (next state ∈ {IDLE, DRAIN}).
- in_frame/in_line:
  - Levels updated in the same cycle as their strobes.
  - frame_start also clears in_line.
  - A repeated frame_start leaves in_frame=1.
- packet_done is never asserted on two consecutive cycles.
- Reset mid-packet: immediate return to reset values, no pulse generated.

Test Plan:
- Frame start: words 16'h0000, 16'h??00 → frame_start=1 and in_frame=1 one cycle after the second word, packet_done pulse same cycle, wait_for_sync=1.
- Long packet, DT 0x2B, WC=4: header words 16'h042B, 16'hEE00, then payload 16'hA1A0, 16'hA3A2, CRC 16'hC1C0:
  - two payload_valid beats 16'hA1A0 and 16'hA3A2 with be=2'b11;
  - no beat for the CRC word;
  - packet_done one cycle after the CRC word.
- Odd WC=3, DT 0x2B:
  - payload words A1A0, C0A2, then 16'h??C1;
  - beats be=11 then be=01 (16'hC0A2 with only lane0 valid);
  - 3 words consumed, packet_done after the third.
- DT 0x12, WC=4: packet fully consumed with packet_done, payload_valid never asserted, hdr_dt=0x12, hdr_wc=4.
- Truncation: valid_in drops after one payload word of a WC=8 packet → trunc_err and packet_done pulse, DRAIN, then IDLE once valid_in=0.
- Async reset asserted mid-PAYLOAD without a clock edge:
  - outputs go to reset values immediately, wait_for_sync=1;
  - the next header after deassertion parses correctly.
